// File: rtl/two_of_five_rx.sv
// Serial 2-out-of-5 receiver: MSB-first codewords -> BCD digits -> packed frame word.
// Optional invalid-codeword counter (err_cnt) enabled by TWO_OF_FIVE_RX_ERRCNT_EN.
module two_of_five_rx #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ser_in,
  input  logic                  ser_vld,
  input  logic                  clr,
  output logic [3:0]            out_digit,
  output logic                  digit_vld,
  output logic                  code_err,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  word_vld,
  output logic                  frame_err,
  output logic                  busy
`ifdef TWO_OF_FIVE_RX_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int AW = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, RX} state_t;
  state_t state_q, state_d;

  logic [3:0]    sh_q;
  logic [2:0]    bit_cnt_q;
  logic [DW-1:0] dig_cnt_q;
  logic [AW-1:0] acc_q;
  logic          bad_q;

  logic          accept, digit_done, frame_done, valid;
  logic [4:0]    code;
  logic [3:0]    dec;
  logic [AW-1:0] acc_next;

  always_comb begin
    accept     = ser_vld && !clr;
    code       = {sh_q, ser_in};
    valid      = ($countones(code) == 2);
    digit_done = accept && (bit_cnt_q == 3'd4);
    frame_done = digit_done && (dig_cnt_q == DW'(DIGITS - 1));
    // Every weight-2 pattern is a legal digit, so the default also marks invalid codes.
    case (code)
      5'b11000: dec = 4'd0;
      5'b00011: dec = 4'd1;
      5'b00101: dec = 4'd2;
      5'b00110: dec = 4'd3;
      5'b01001: dec = 4'd4;
      5'b01010: dec = 4'd5;
      5'b01100: dec = 4'd6;
      5'b10001: dec = 4'd7;
      5'b10010: dec = 4'd8;
      5'b10100: dec = 4'd9;
      default:  dec = 4'hF;
    endcase
    acc_next = (acc_q << 4) | AW'(dec);
  end

  // busy is the state register itself: RX from first accepted bit to frame completion.
  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = IDLE;
    else if (accept)
      state_d = frame_done ? IDLE : RX;
  end

  assign busy = (state_q == RX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      dig_cnt_q <= '0;
      acc_q     <= '0;
      bad_q     <= 1'b0;
      out_digit <= '0;
      digit_vld <= 1'b0;
      code_err  <= 1'b0;
      out_word  <= '0;
      word_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_vld <= 1'b0;
      code_err  <= 1'b0;
      word_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (clr) begin
        sh_q      <= '0;
        bit_cnt_q <= '0;
        dig_cnt_q <= '0;
        acc_q     <= '0;
        bad_q     <= 1'b0;
      end else if (accept) begin
        if (digit_done) begin
          bit_cnt_q <= '0;
          out_digit <= dec;
          digit_vld <= 1'b1;
          code_err  <= !valid;
          if (frame_done) begin
            // A frame with any bad digit leaves the previous good word visible.
            if (bad_q || !valid) begin
              frame_err <= 1'b1;
            end else begin
              out_word <= acc_next;
              word_vld <= 1'b1;
            end
            dig_cnt_q <= '0;
            acc_q     <= '0;
            bad_q     <= 1'b0;
          end else begin
            dig_cnt_q <= dig_cnt_q + DW'(1);
            acc_q     <= acc_next;
            bad_q     <= bad_q || !valid;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          sh_q      <= {sh_q[2:0], ser_in};
        end
      end
    end
  end

`ifdef TWO_OF_FIVE_RX_ERRCNT_EN
  // Saturating; deliberately immune to clr so it survives frame aborts.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (digit_done && !valid && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
